// File: rtl/ahb_slave_regfile_if.sv
// AHB-Lite signal bundle between the bus master and the register-file slave.
interface ahb_slave_regfile_if;
  logic [1:0]  sel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output sel, haddr, hwrite, hsize, htrans, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  sel, haddr, hwrite, hsize, htrans, hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_regfile.sv
// AHB-Lite slave with a word-addressed register file, programmable wait states
// and a two-cycle ERROR response for illegal transfers.
module ahb_slave_regfile #(
  parameter logic [1:0]  SLAVE_ID    = 2'b01,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                hclk,
  input logic                hreset,
  ahb_slave_regfile_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [AW-1:0] word_q, word_nxt;
  logic          write_q, write_nxt;
  logic          readyout_q, readyout_nxt;
  logic          resp_q, resp_nxt;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  logic          accept_c;
  logic          err_c;
  logic [AW-1:0] addr_word_c;
  logic          commit_c;
  logic          load_rd_c;
  logic [AW-1:0] rd_word_c;
  logic          unused_c;

  // Address-phase decode: selection, word index and legality of the transfer.
  always_comb begin
    accept_c    = (bus.sel == SLAVE_ID) && bus.hready && bus.htrans[1];
    addr_word_c = bus.haddr[AW+1:2];
    err_c       = (bus.hsize != 3'b010) || (bus.haddr[1:0] != 2'b00) ||
                  (bus.haddr >= LIMIT);
    commit_c    = (state == S_LAST) && write_q;
    unused_c    = bus.htrans[0];
  end

  // Next-state, wait counter and read-capture decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word_q;
    write_nxt = write_q;
    load_rd_c = 1'b0;
    rd_word_c = word_q;
    case (state)
      S_IDLE, S_LAST, S_ERR2: begin
        state_nxt = S_IDLE;
        if (accept_c) begin
          word_nxt  = addr_word_c;
          write_nxt = bus.hwrite;
          if (err_c) begin
            state_nxt = S_ERR1;
          end else if (WS != 3'd0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS;
          end else begin
            state_nxt = S_LAST;
            load_rd_c = !bus.hwrite;
            rd_word_c = addr_word_c;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          state_nxt = S_LAST;
          load_rd_c = !write_q;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
    readyout_nxt = !((state_nxt == S_WAIT) || (state_nxt == S_ERR1));
    resp_nxt     = (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
  end

  // State, response and memory registers; read data forwards a same-edge write.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      word_q     <= '0;
      write_q    <= 1'b0;
      readyout_q <= 1'b1;
      resp_q     <= 1'b0;
      rdata_q    <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      word_q     <= word_nxt;
      write_q    <= write_nxt;
      readyout_q <= readyout_nxt;
      resp_q     <= resp_nxt;
      if (commit_c) mem[word_q] <= bus.hwdata;
      if (load_rd_c) begin
        rdata_q <= (commit_c && (word_q == rd_word_c)) ? bus.hwdata : mem[rd_word_c];
      end
    end
  end

  assign bus.hreadyout = readyout_q;
  assign bus.hresp     = resp_q;
  assign bus.hrdata    = rdata_q;
endmodule

// File: tb/tb_ahb_slave_regfile.sv
// Scoreboard bench for ahb_slave_regfile: one instance with one wait state,
// one with zero wait states for pipelined read-after-write.
module tb_ahb_slave_regfile;
  typedef struct packed {
    logic        first_resp;
    logic        resp;
    logic [3:0]  stalls;
    logic [31:0] rdata;
  } res_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [1:0]  sel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] hwdata;
  logic        use0;
  logic        obs_ready, obs_resp;
  logic [31:0] obs_rdata;

  res_t        exp_q[$];
  logic [31:0] model [16];
  int          checks = 0;
  int          errors = 0;

  ahb_slave_regfile_if bus1 ();
  ahb_slave_regfile_if bus0 ();

  always #5 hclk = ~hclk;

  // Shared stimulus; the inactive instance is deselected.
  always_comb begin
    bus1.sel = use0 ? 2'b00 : sel;  bus0.sel = use0 ? sel : 2'b00;
    bus1.haddr = haddr;   bus0.haddr = haddr;
    bus1.hwrite = hwrite; bus0.hwrite = hwrite;
    bus1.hsize = hsize;   bus0.hsize = hsize;
    bus1.htrans = htrans; bus0.htrans = htrans;
    bus1.hready = hready; bus0.hready = hready;
    bus1.hwdata = hwdata; bus0.hwdata = hwdata;
  end

  assign obs_ready = use0 ? bus0.hreadyout : bus1.hreadyout;
  assign obs_resp  = use0 ? bus0.hresp     : bus1.hresp;
  assign obs_rdata = use0 ? bus0.hrdata    : bus1.hrdata;

  ahb_slave_regfile #(.SLAVE_ID(2'b01), .DEPTH(16), .WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hreset(hreset), .bus(bus1));
  ahb_slave_regfile #(.SLAVE_ID(2'b01), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .bus(bus0));

  function automatic res_t exp_ok(input logic wr, input logic [31:0] data);
    res_t e;
    e.first_resp = 1'b0;
    e.resp       = 1'b0;
    e.stalls     = use0 ? 4'd0 : 4'd1;
    e.rdata      = wr ? 32'd0 : data;
    return e;
  endfunction

  function automatic res_t exp_err();
    res_t e;
    e.first_resp = 1'b1;
    e.resp       = 1'b1;
    e.stalls     = 4'd1;
    e.rdata      = 32'd0;
    return e;
  endfunction

  // Single non-pipelined transfer; entered and left just after a rising edge.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [2:0] size, output res_t r);
    int n;
    r = '0;
    sel = 2'b01; haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = wdata;
    n = 0;
    @(negedge hclk);
    r.first_resp = obs_resp;
    while (obs_ready !== 1'b1 && n < 15) begin
      n++;
      @(negedge hclk);
    end
    r.stalls = 4'(n);
    r.resp   = obs_resp;
    if (!wr && obs_resp === 1'b0) r.rdata = obs_rdata;
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    res_t got, want;
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    @(negedge hclk);
    checks++;
    if ({bus1.hreadyout, bus1.hresp, bus1.hrdata} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_ws1: got ready=%b resp=%b rdata=%h, expected 1 0 00000000",
               bus1.hreadyout, bus1.hresp, bus1.hrdata);
    end
    checks++;
    if ({bus0.hreadyout, bus0.hresp, bus0.hrdata} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_ws0: got ready=%b resp=%b rdata=%h, expected 1 0 00000000",
               bus0.hreadyout, bus0.hresp, bus0.hrdata);
    end
    @(posedge hclk); #1;
    exp_q.push_back(exp_ok(1'b0, model[3]));
    do_xfer(32'h0C, 1'b0, 32'd0, 3'b010, got);
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_read_w3: got %h, expected %h", got, want);
    end
  endtask

  task automatic test_write_read();
    res_t got, want;
    logic [31:0] addr [2] = '{32'h0C, 32'h0C};
    logic        wr   [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) model[addr[i][5:2]] = 32'hDEADBEEF;
      exp_q.push_back(exp_ok(wr[i], model[addr[i][5:2]]));
      do_xfer(addr[i], wr[i], 32'hDEADBEEF, 3'b010, got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL write_read[%0d]: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t got, want;
    use0 = 1'b1;
    sel = 2'b01; haddr = 32'h08; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    @(posedge hclk); #1;
    hwdata = 32'h11; haddr = 32'h08; hwrite = 1'b0; htrans = 2'b10;
    exp_q.push_back(exp_ok(1'b0, 32'h11));
    @(negedge hclk);
    checks++;
    if ({obs_ready, obs_resp} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_write_last: got ready=%b resp=%b, expected 1 0", obs_ready, obs_resp);
    end
    @(posedge hclk); #1;
    htrans = 2'b00;
    @(negedge hclk);
    got = '0;
    got.first_resp = obs_resp;
    got.resp       = obs_resp;
    got.stalls     = obs_ready ? 4'd0 : 4'd1;
    got.rdata      = obs_rdata;
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL b2b_forward_read: got %h, expected %h", got, want);
    end
    @(posedge hclk); #1;
    use0 = 1'b0;
  endtask

  task automatic test_errors();
    res_t got, want;
    logic [31:0] addr [5] = '{32'h00, 32'h40, 32'h05, 32'h00, 32'h3C};
    logic        wr   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  size [5] = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b010};
    logic        bad  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] wd   [5] = '{32'h12345678, 32'hBAD0BAD0, 32'hBAD1BAD1, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      if (bad[i]) begin
        exp_q.push_back(exp_err());
      end else begin
        if (wr[i]) model[addr[i][5:2]] = wd[i];
        exp_q.push_back(exp_ok(wr[i], model[addr[i][5:2]]));
      end
      do_xfer(addr[i], wr[i], wd[i], size[i], got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL errors[%0d]: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_deselect();
    res_t got, want;
    model[4] = 32'hA5A5A5A5;
    exp_q.push_back(exp_ok(1'b1, 32'd0));
    do_xfer(32'h10, 1'b1, 32'hA5A5A5A5, 3'b010, got);
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL deselect_setup: got %h, expected %h", got, want);
    end
    sel = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    hwdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      checks++;
      if ({obs_ready, obs_resp} !== 2'b10) begin
        errors++;
        $display("FAIL deselect_resp[%0d]: got ready=%b resp=%b, expected 1 0",
                 i, obs_ready, obs_resp);
      end
      @(posedge hclk); #1;
    end
    htrans = 2'b00;
    exp_q.push_back(exp_ok(1'b0, model[4]));
    do_xfer(32'h10, 1'b0, 32'd0, 3'b010, got);
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL deselect_readback: got %h, expected %h", got, want);
    end
  endtask

  task automatic test_reset_in_wait();
    res_t got, want;
    sel = 2'b01; haddr = 32'h04; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = 32'h55;
    @(negedge hclk);
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_stall: got ready=%b, expected 0", obs_ready);
    end
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    @(negedge hclk);
    checks++;
    if ({obs_ready, obs_resp} !== 2'b10) begin
      errors++;
      $display("FAIL rst_wait_ready: got ready=%b resp=%b, expected 1 0", obs_ready, obs_resp);
    end
    @(posedge hclk); #1;
    exp_q.push_back(exp_ok(1'b0, model[1]));
    do_xfer(32'h04, 1'b0, 32'd0, 3'b010, got);
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL rst_wait_readback: got %h, expected %h", got, want);
    end
  endtask

  initial begin
    hreset = 1'b1; use0 = 1'b0;
    sel = 2'b00; haddr = 32'd0; hwrite = 1'b0; hsize = 3'b010;
    htrans = 2'b00; hready = 1'b1; hwdata = 32'd0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_deselect();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
